// File: rtl/dvp_pkg.sv
// ---------------------------------------------------------------------------
// dvp_pkg
// Shared definitions for the DVP RGB565 transmitter:
//   - dvp_state_e      : frame-level FSM states
//   - Def* constants   : default timing for the ov5640 1280x720 configuration
//   - rgb888_to_rgb565 : packs a 24-bit pixel into the 16-bit RGB565 word;
//                        the high byte is sent first on the DVP bus
// ---------------------------------------------------------------------------
package dvp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } dvp_state_e;

    localparam int unsigned DefHActive  = 1280;
    localparam int unsigned DefHBlank   = 10;
    localparam int unsigned DefVActive  = 720;
    localparam int unsigned DefVsLines  = 4;
    localparam int unsigned DefVBack    = 8;
    localparam int unsigned DefVFront   = 4;
    localparam logic [23:0] DefFillPixel = 24'h000000;

    // {R[7:0],G[7:0],B[7:0]} -> {R[7:3],G[7:2],B[7:3]}
    function automatic logic [15:0] rgb888_to_rgb565(input logic [23:0] pix);
        return {pix[23:19], pix[15:10], pix[7:3]};
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// ---------------------------------------------------------------------------
// dvp_timing_gen
// Frame timing for the DVP source: horizontal/vertical counters and the
// frame FSM. All outputs are combinational decodes of the current counter
// and state values; the caller registers them.
//
// Ports:
//   clk_i    byte clock
//   rst_i    synchronous reset, active high
//   en_i     frame enable, only looked at in idle and at the end of a frame
//   vsync_o  current line belongs to the vsync block
//   href_o   current byte slot is an active byte of an active line
//   fetch_o  current byte slot is the first byte of a pixel (pixel fetch)
//   busy_o   a frame is in progress
// ---------------------------------------------------------------------------
module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_BLANK  = DefHBlank,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned VS_LINES = DefVsLines,
    parameter int unsigned V_BACK   = DefVBack,
    parameter int unsigned V_FRONT  = DefVFront
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic vsync_o,
    output logic href_o,
    output logic fetch_o,
    output logic busy_o
);

    localparam int unsigned LineLen = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HW      = (LineLen > 1) ? $clog2(LineLen) : 1;

    localparam int unsigned VMaxA = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int unsigned VMaxB = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int unsigned VMax  = (VMaxA > VMaxB) ? VMaxA : VMaxB;
    localparam int unsigned VW    = (VMax > 1) ? $clog2(VMax) : 1;

    dvp_state_e    state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    logic [VW-1:0] v_last;
    logic          line_end;
    logic          block_end;

    // Index of the last line of the block the FSM is currently in.
    always_comb begin
        v_last = '0;
        unique case (state_q)
            StVsync:  v_last = VW'(VS_LINES - 1);
            StVback:  v_last = VW'(V_BACK - 1);
            StActive: v_last = VW'(V_ACTIVE - 1);
            StVfront: v_last = VW'(V_FRONT - 1);
            default:  v_last = '0;
        endcase
    end

    assign line_end  = (h_cnt_q == HW'(LineLen - 1));
    assign block_end = line_end && (v_cnt_q == v_last);

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;

        if (state_q == StIdle) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (en_i) begin
                state_d = StVsync;
            end
        end else begin
            h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
            if (line_end) begin
                // v_cnt counts lines within the current block.
                v_cnt_d = block_end ? '0 : v_cnt_q + VW'(1);
            end
            if (block_end) begin
                unique case (state_q)
                    StVsync:  state_d = StVback;
                    StVback:  state_d = StActive;
                    StActive: state_d = StVfront;
                    StVfront: state_d = en_i ? StVsync : StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign vsync_o = (state_q == StVsync);
    assign href_o  = (state_q == StActive) && (h_cnt_q < HW'(2 * H_ACTIVE));
    // Even byte slots of the active region carry the pixel's first byte.
    assign fetch_o = href_o && !h_cnt_q[0];

endmodule

// File: rtl/dvp_rgb565_tx.sv
// ---------------------------------------------------------------------------
// dvp_rgb565_tx
// DVP (OV5640-style) source. Consumes 24-bit RGB pixels and emits RGB565
// bytes (high byte first) with vsync/href framing on cam_clk.
//
// Ports:
//   cam_clk    byte clock, rising edge
//   cam_rst    synchronous reset, active high; aborts any frame in progress
//   en         frame enable, sampled only at frame boundaries
//   s_data     {R,G,B} upstream pixel
//   s_valid    s_data valid
//   s_ready    pixel consumed this cycle (combinational)
//   dvp_vsync  frame sync, registered
//   dvp_href   line valid, registered
//   dvp_data   RGB565 byte, registered, 0 while dvp_href is low
//   underflow  pulse when FILL_PIXEL replaces a missing upstream pixel
//   busy       frame in progress
// ---------------------------------------------------------------------------
module dvp_rgb565_tx
    import dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DefHActive,
    parameter int unsigned H_BLANK    = DefHBlank,
    parameter int unsigned V_ACTIVE   = DefVActive,
    parameter int unsigned VS_LINES   = DefVsLines,
    parameter int unsigned V_BACK     = DefVBack,
    parameter int unsigned V_FRONT    = DefVFront,
    parameter logic [23:0] FILL_PIXEL = DefFillPixel
) (
    input  logic        cam_clk,
    input  logic        cam_rst,
    input  logic        en,
    input  logic [23:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        underflow,
    output logic        busy
);

    logic vsync_dec;
    logic href_dec;
    logic fetch;
    logic frame_busy;

    dvp_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk_i   (cam_clk),
        .rst_i   (cam_rst),
        .en_i    (en),
        .vsync_o (vsync_dec),
        .href_o  (href_dec),
        .fetch_o (fetch),
        .busy_o  (frame_busy)
    );

    logic [23:0] pix;
    logic [15:0] pix565;

    logic [7:0] lo_q, lo_d;
    logic [7:0] data_q, data_d;
    logic       href_q;
    logic       vsync_q;

    // A missing pixel is replaced, never waited for, so line timing is fixed.
    assign pix    = s_valid ? s_data : FILL_PIXEL;
    assign pix565 = rgb888_to_rgb565(pix);

    assign s_ready   = fetch;
    assign underflow = fetch && !s_valid;
    assign busy      = frame_busy;

    // Fetch slot sends the high byte and parks the low byte for the next slot.
    always_comb begin
        lo_d   = lo_q;
        data_d = '0;
        if (fetch) begin
            data_d = pix565[15:8];
            lo_d   = pix565[7:0];
        end else if (href_dec) begin
            data_d = lo_q;
        end
    end

    always_ff @(posedge cam_clk) begin
        if (cam_rst) begin
            lo_q    <= '0;
            data_q  <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            data_q  <= data_d;
            href_q  <= href_dec;
            vsync_q <= vsync_dec;
        end
    end

    assign dvp_vsync = vsync_q;
    assign dvp_href  = href_q;
    assign dvp_data  = data_q;

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Bench for dvp_rgb565_tx with a small frame (L=14, frame=84 cycles).
module tb_dvp_rgb565_tx;

    localparam int unsigned HA  = 4;
    localparam int unsigned HB  = 6;
    localparam int unsigned VA  = 3;
    localparam int unsigned VSL = 1;
    localparam int unsigned VB  = 1;
    localparam int unsigned VF  = 1;
    localparam logic [23:0] FILL = 24'h000000;
    localparam int L     = 2 * HA + HB;
    localparam int FRAME = (VSL + VB + VA + VF) * L;

    logic        cam_clk = 1'b0;
    logic        cam_rst;
    logic        en;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        underflow;
    logic        busy;

    always #5 cam_clk = ~cam_clk;

    dvp_rgb565_tx #(
        .H_ACTIVE   (HA),
        .H_BLANK    (HB),
        .V_ACTIVE   (VA),
        .VS_LINES   (VSL),
        .V_BACK     (VB),
        .V_FRONT    (VF),
        .FILL_PIXEL (FILL)
    ) dut (
        .cam_clk   (cam_clk),
        .cam_rst   (cam_rst),
        .en        (en),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dvp_vsync (dvp_vsync),
        .dvp_href  (dvp_href),
        .dvp_data  (dvp_data),
        .underflow (underflow),
        .busy      (busy)
    );

    typedef struct {
        logic [23:0] pix;
        bit          valid;
        logic [7:0]  hi;
        logic [7:0]  lo;
        bit          uf;
    } vec_t;

    vec_t tbl[12];
    int   tbl_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame position as a plain cycle index.
    bit         m_run;
    int         m_k;
    logic       m_href, m_vs;
    logic [7:0] m_data, m_lo;

    int cyc;
    int n_vs, n_href, n_busy, n_ready, n_uf;
    logic prev_href, prev_vs;
    int vs_rise[$];
    int href_rise[$];
    logic [7:0] cap[$];

    function automatic bit f_vs(bit run, int k);
        return run && ((k / L) < VSL);
    endfunction

    function automatic bit f_act(bit run, int k);
        int line;
        line = k / L;
        return run && (line >= VSL + VB) && (line < VSL + VB + VA) && ((k % L) < 2 * HA);
    endfunction

    function automatic bit f_fetch(bit run, int k);
        return f_act(run, k) && (((k % L) % 2) == 0);
    endfunction

    function automatic logic [15:0] to565(logic [23:0] p);
        int w;
        w = (int'(p[23:16]) / 8) * 2048 + (int'(p[15:8]) / 4) * 32 + int'(p[7:0]) / 8;
        return w[15:0];
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic reset_stats();
        n_vs = 0; n_href = 0; n_busy = 0; n_ready = 0; n_uf = 0;
        href_rise.delete();
        cap.delete();
    endtask

    // One clock: check at negedge, advance model, return at posedge+1.
    task automatic cycle();
        logic [23:0] pix;
        logic [15:0] w;
        bit          fa, fv, ft;
        @(negedge cam_clk);
        fa = f_act(m_run, m_k);
        fv = f_vs(m_run, m_k);
        ft = f_fetch(m_run, m_k);
        if (!cam_rst) begin
            chk("s_ready", s_ready, ft);
            chk("underflow", underflow, ft && !s_valid);
            chk("busy", busy, m_run);
        end
        chk("dvp_vsync", dvp_vsync, m_vs);
        chk("dvp_href", dvp_href, m_href);
        chk("dvp_data", dvp_data, m_data);

        if (dvp_vsync === 1'b1) n_vs++;
        if (dvp_vsync === 1'b1 && prev_vs !== 1'b1) vs_rise.push_back(cyc);
        if (dvp_href === 1'b1) begin
            n_href++;
            cap.push_back(dvp_data);
        end
        if (dvp_href === 1'b1 && prev_href !== 1'b1) href_rise.push_back(cyc);
        if (busy === 1'b1) n_busy++;
        if (s_ready === 1'b1) n_ready++;
        if (underflow === 1'b1) n_uf++;
        prev_vs   = dvp_vsync;
        prev_href = dvp_href;

        if (cam_rst) begin
            m_run = 0; m_k = 0; m_href = 0; m_vs = 0; m_data = 0; m_lo = 0;
        end else begin
            pix    = s_valid ? s_data : FILL;
            w      = to565(pix);
            m_vs   = fv;
            m_href = fa;
            if (ft) begin
                m_data = w[15:8];
                m_lo   = w[7:0];
            end else if (fa) begin
                m_data = m_lo;
            end else begin
                m_data = 8'h00;
            end
            if (!m_run) begin
                if (en) begin m_run = 1; m_k = 0; end
            end else if (m_k == FRAME - 1) begin
                m_k = 0;
                if (!en) m_run = 0;
            end else begin
                m_k++;
            end
        end
        @(posedge cam_clk);
        #1;
        cyc++;
    endtask

    // mode 0: table pixels at fetch slots; mode 1: random pixels.
    task automatic run_cycles(int n, int mode);
        for (int i = 0; i < n; i++) begin
            if (f_fetch(m_run, m_k) && mode == 0 && tbl_idx < 12) begin
                s_data  = tbl[tbl_idx].pix;
                s_valid = tbl[tbl_idx].valid;
                tbl_idx++;
            end else if (f_fetch(m_run, m_k)) begin
                s_data  = $urandom;
                s_valid = ($urandom_range(0, 3) != 0);
            end else begin
                s_data  = $urandom;
                s_valid = $urandom_range(0, 1) == 1;
            end
            cycle();
        end
    endtask

    initial begin
        logic [15:0] wexp;
        int          uf_exp;

        tbl[0]  = '{24'hF8FC00, 1'b1, 8'hFF, 8'hE0, 1'b0};
        tbl[1]  = '{24'h123456, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{24'h0000F8, 1'b1, 8'h00, 8'h1F, 1'b0};
        tbl[3]  = '{24'h123456, 1'b1, 8'h11, 8'hAA, 1'b0};
        tbl[4]  = '{24'hFFFFFF, 1'b1, 8'hFF, 8'hFF, 1'b0};
        tbl[5]  = '{24'h808080, 1'b1, 8'h84, 8'h10, 1'b0};
        tbl[6]  = '{24'h00FC00, 1'b1, 8'h07, 8'hE0, 1'b0};
        tbl[7]  = '{24'hF80000, 1'b1, 8'hF8, 8'h00, 1'b0};
        tbl[8]  = '{24'h070307, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{24'hABCDEF, 1'b1, 8'hAE, 8'h7D, 1'b0};
        tbl[10] = '{24'h000000, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{24'hF8FC00, 1'b1, 8'hFF, 8'hE0, 1'b0};

        cam_rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
        m_run = 0; m_k = 0; m_href = 0; m_vs = 0; m_data = 0; m_lo = 0;
        cyc = 0; prev_vs = 0; prev_href = 0; tbl_idx = 0;
        reset_stats();
        repeat (2) @(posedge cam_clk);
        #1;

        // Reset state.
        cycle();
        cam_rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        run_cycles(4, 1);

        // Frame 1: table-driven pixels, timing counts.
        en = 1'b1;
        run_cycles(1, 1);
        reset_stats();
        tbl_idx = 0;
        run_cycles(FRAME, 0);
        chk("f1_vsync_cycles", n_vs, 14);
        chk("f1_href_cycles", n_href, 24);
        chk("f1_href_pulses", href_rise.size(), 3);
        for (int i = 1; i < href_rise.size(); i++)
            chk("f1_href_spacing", href_rise[i] - href_rise[i-1], L);
        chk("f1_busy_cycles", n_busy, FRAME);
        chk("f1_ready_pulses", n_ready, 12);
        uf_exp = 0;
        for (int i = 0; i < 12; i++) uf_exp += int'(tbl[i].uf);
        chk("f1_underflows", n_uf, uf_exp);
        chk("f1_bytes", cap.size(), 24);
        for (int i = 0; i < 12 && 2 * i + 1 < cap.size(); i++) begin
            chk("tbl_hi", cap[2*i], tbl[i].hi);
            chk("tbl_lo", cap[2*i+1], tbl[i].lo);
            wexp = to565(tbl[i].valid ? tbl[i].pix : FILL);
            chk("loop_word", {cap[2*i], cap[2*i+1]}, wexp);
        end

        // Frame 2: random pixels, back-to-back vsync spacing.
        reset_stats();
        run_cycles(FRAME, 1);
        chk("f2_vsync_cycles", n_vs, 14);
        chk("f2_busy_cycles", n_busy, FRAME);
        chk("vsync_rises", vs_rise.size(), 2);
        if (vs_rise.size() >= 2) chk("vsync_period", vs_rise[1] - vs_rise[0], FRAME);

        // Frame 3: en dropped during ACTIVE, frame completes then idles.
        reset_stats();
        run_cycles(40, 1);
        en = 1'b0;
        run_cycles(FRAME - 40, 1);
        chk("f3_busy_cycles", n_busy, FRAME);
        chk("f3_href_pulses", href_rise.size(), 3);
        chk("f3_ready_pulses", n_ready, 12);
        reset_stats();
        run_cycles(30, 1);
        chk("idle_busy_cycles", n_busy, 0);
        chk("idle_vsync_cycles", n_vs, 0);
        chk("idle_busy", busy, 0);

        // Reset at h_cnt=5 of the second active line.
        en = 1'b1;
        run_cycles(1, 1);
        for (int i = 0; i < 100 && !(m_run && m_k == 3 * L + 5); i++) run_cycles(1, 1);
        chk("pre_rst_href", dvp_href, 1);
        cam_rst = 1'b1;
        en = 1'b0;
        cycle();
        cam_rst = 1'b0;
        chk("post_rst_vsync", dvp_vsync, 0);
        chk("post_rst_href", dvp_href, 0);
        chk("post_rst_data", dvp_data, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", s_ready, 0);
        chk("post_rst_uf", underflow, 0);
        run_cycles(3, 1);
        en = 1'b1;
        run_cycles(1, 1);
        reset_stats();
        en = 1'b0;
        run_cycles(FRAME, 1);
        chk("f4_vsync_cycles", n_vs, 14);
        chk("f4_href_pulses", href_rise.size(), 3);
        chk("f4_ready_pulses", n_ready, 12);
        chk("f4_busy_cycles", n_busy, FRAME);
        run_cycles(10, 1);
        chk("end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_rgb565_tx.md
Name: dvp_rgb565_tx

Overview:
- DVP (OV5640-style) source: serializes a 24-bit RGB pixel stream into 8-bit RGB565 bytes, two bytes per pixel, with generated vsync/href timing.
- Opposite end of the camera capture path. Used as an on-board camera emulator / loopback source so cmos_capture_data and ov5640_cdc can be exercised without a sensor.
- Single clock domain: cam_clk is the emitted byte (pclk) clock.

Parameters:
- H_ACTIVE, 1280, active pixels per line; a line carries 2*H_ACTIVE byte cycles.
- H_BLANK, 10, blank byte cycles after the active bytes of every line; must be >= 1.
- V_ACTIVE, 720, active lines per frame.
- VS_LINES, 4, lines with dvp_vsync high at frame start.
- V_BACK, 8, blank lines between vsync and the first active line.
- V_FRONT, 4, blank lines after the last active line.
- FILL_PIXEL, 24'h000000, pixel emitted when upstream underflows.

Ports:
- cam_clk  in  1  byte clock; all logic is on its rising edge.
- cam_rst  in  1  synchronous reset, active high.
- en  in  1  frame enable, sampled only at frame boundaries.
- s_data  in  24  {R[7:0],G[7:0],B[7:0]} upstream pixel.
- s_valid  in  1  s_data valid.
- s_ready  out  1  pixel consumed this cycle.
- dvp_vsync  out  1  frame sync, active high.
- dvp_href  out  1  line valid, high on every active byte.
- dvp_data  out  8  RGB565 byte.
- underflow  out  1  one-cycle pulse when a fill pixel replaces a missing upstream pixel.
- busy  out  1  high from frame start until the frame ends.

Behaviour:
- Reset: state IDLE; counters 0; dvp_vsync, dvp_href, dvp_data, s_ready, underflow and busy all 0. A reset mid-frame aborts the frame immediately; there is no partial-frame completion.
- Line length L = 2*H_ACTIVE+H_BLANK byte cycles. h_cnt runs 0..L-1 and wraps to 0. v_cnt advances when h_cnt wraps.
- Frame length = (VS_LINES+V_BACK+V_ACTIVE+V_FRONT)*L cycles.
- FSM (the state changes only on line wrap, except IDLE):
  - IDLE: outputs low. When en=1, go to VSYNC on the next cycle with h_cnt=0 and v_cnt=0.
  - VSYNC: dvp_vsync=1 for VS_LINES lines, then go to VBACK.
  - VBACK: V_BACK lines, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines, then go to VFRONT.
  - VFRONT: V_FRONT lines. At the end, go to VSYNC if en=1, else IDLE.
  - Deasserting en mid-frame has no effect until the frame ends.
- busy=1 in every state except IDLE.
- ACTIVE line:
  - dvp_href=1 for the registered outputs where h_cnt is 0..2*H_ACTIVE-1, and 0 during blank.
  - s_ready=1 (combinational) on even h_cnt within the active region, i.e. the cycle the pixel is fetched.
  - Fetch: the pixel is taken if s_valid=1; otherwise FILL_PIXEL is used and underflow pulses in that same cycle.
  - Byte order, with P = the fetched pixel:
    - High byte {P[23:19],P[15:13]} on dvp_data the cycle after fetch.
    - Low byte {P[12:10],P[7:3]} on the following cycle.
  - Outputs are registered. dvp_href, dvp_vsync and dvp_data are aligned with each other, lagging counter decode by 1 cycle.
- dvp_data=0 whenever dvp_href=0.
- s_ready is never high outside the active bytes of ACTIVE lines. s_valid is ignored then; upstream holds data, nothing is dropped.
- Exactly H_ACTIVE*V_ACTIVE pixels are consumed per frame, counting fills.

Decomposition:
- Shared package (dvp_pkg): FSM state enum {IDLE,VSYNC,VBACK,ACTIVE,VFRONT}, an RGB888-to-RGB565 byte-split function, and the default timing constants matching the ov5640 1280x720 configuration.
- One sub-module, dvp_timing_gen: h_cnt/v_cnt and the FSM, producing vsync/href/fetch strobes. dvp_rgb565_tx adds the pixel fetch, byte mux and output registers.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=6, V_ACTIVE=3, VS_LINES=1, V_BACK=1, V_FRONT=1, giving L=14 and a frame of 84 cycles.
- Reset, then en=1 -> dvp_vsync high for exactly 14 cycles. href pulses are 8 cycles wide, 14 apart, 3 per frame. busy is high for 84 cycles. With en still 1, the next vsync starts 84 cycles after the first.
- s_valid always 1, pixel 24'hF8FC00 -> bytes 0xFF, 0xE0. Pixel 24'h0000F8 -> bytes 0x00, 0x1F. 12 s_ready pulses per frame, and no underflow.
- s_valid=0 on the 2nd fetch of line 1 -> FILL_PIXEL emitted as bytes 0x00, 0x00; a single underflow pulse; the stream continues with the next pixel, and frame timing is unchanged.
- en dropped during the ACTIVE state -> the current frame completes all 3 lines and VFRONT, then the block goes IDLE with busy=0. No vsync follows.
- cam_rst asserted at h_cnt=5 of the 2nd active line -> the next cycle shows all outputs 0 and the state IDLE. A following en=1 starts a fresh full frame.
- Loopback through cmos_capture_data -> the received RGB565 words equal the sent pixels' top bits for all 12 pixels.
